// File: rtl/npu_sort_pkg.sv
// Shared definitions for the top-5 merge-sort chain: state encodings and sorter constants.
package npu_sort_pkg;

  localparam int          TOPK      = 5;
  localparam logic [7:0]  SORT_MIN  = 8'h80;
  localparam int          GRP_W_DEF = 16;

  // Gray-coded so adjacent main-path transitions flip a single bit.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    CLEAR = 3'b001,
    ISSUE = 3'b011,
    GAP   = 3'b010,
    DRAIN = 3'b110,
    DONE  = 3'b111
  } state_t;

  // What the CLEAR state leads to once its sorter_clr pulse is out.
  typedef enum logic [1:0] {
    CLR_JOB   = 2'd0,
    CLR_ABORT = 2'd1,
    CLR_TMO   = 2'd2
  } clr_mode_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/topk_sort_ctrl.sv
// Sequencer for the E1/E2 -> E3 top-5 sort chain: clear, paced issue, drain, done/err.
// Optional drain watchdog enabled by defining SORT_TIMEOUT_EN.
module topk_sort_ctrl
  import npu_sort_pkg::*;
#(
  parameter int GRP_W       = GRP_W_DEF,
  parameter int SORT_GAP    = 8,
  parameter int PIPE_LAT    = 7,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [GRP_W-1:0] num_groups,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             sorter_clr,
  output logic             sort_en,
  output logic             last_sort,
  output logic [GRP_W-1:0] grp_index,
  input  logic             sorter_valid,
  input  logic             last_sort_o,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // One counter serves both the issue gap and the drain watchdog.
  localparam int CNT_MAX = imax(imax(SORT_GAP, TIMEOUT_CYC), PIPE_LAT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state_q, state_d;
  clr_mode_t        mode_q, mode_d;
  logic [GRP_W-1:0] num_q, grp_cnt_q, vld_cnt_q, vld_inc;
  logic [CNT_W-1:0] cnt_q;
  logic             last_seen_q;
  logic             sv_cnt, fin, tmo, err_chk;
  logic [GRP_W:0]   tot_ext;

  assign sv_cnt  = sorter_valid && (state_q == ISSUE || state_q == GAP || state_q == DRAIN);
  assign vld_inc = (&vld_cnt_q) ? vld_cnt_q : vld_cnt_q + GRP_W'(1);
  assign tot_ext = {1'b0, vld_cnt_q} + {{GRP_W{1'b0}}, sv_cnt};
  assign err_chk = (tot_ext != {1'b0, num_q});

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    src_ready = 1'b0;
    sort_en   = 1'b0;
    last_sort = 1'b0;
    grp_index = '0;
    fin       = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (num_groups != '0) begin
            state_d = CLEAR;
            mode_d  = CLR_JOB;
          end else begin
            state_d = DONE;
          end
        end
      end
      CLEAR: begin
        case (mode_q)
          CLR_ABORT: state_d = IDLE;
          CLR_TMO:   state_d = DONE;
          default:   state_d = ISSUE;
        endcase
      end
      ISSUE: begin
        if (src_valid) begin
          src_ready = 1'b1;
          sort_en   = 1'b1;
          last_sort = (grp_cnt_q == num_q - GRP_W'(1));
          grp_index = grp_cnt_q;
          state_d   = GAP;
        end
      end
      GAP: begin
        // The final result may already be back when the last gap expires.
        if (cnt_q == CNT_W'(1)) begin
          if (grp_cnt_q != num_q) begin
            state_d = ISSUE;
          end else if (last_seen_q || (sorter_valid && last_sort_o)) begin
            state_d = DONE;
            fin     = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (sorter_valid && last_sort_o) begin
          state_d = DONE;
          fin     = 1'b1;
        end
`ifdef SORT_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = CLEAR;
          mode_d  = CLR_TMO;
          tmo     = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && state_q != IDLE) begin
      state_d   = CLEAR;
      mode_d    = CLR_ABORT;
      src_ready = 1'b0;
      sort_en   = 1'b0;
      last_sort = 1'b0;
      grp_index = '0;
      fin       = 1'b0;
      tmo       = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      mode_q      <= CLR_JOB;
      num_q       <= '0;
      grp_cnt_q   <= '0;
      vld_cnt_q   <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      sorter_clr  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sorter_clr <= (state_d == CLEAR);
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE);

      if (state_q == IDLE && start && !abort) begin
        num_q <= num_groups;
        err   <= 1'b0;
      end

      if (state_q == CLEAR) begin
        grp_cnt_q   <= '0;
        vld_cnt_q   <= '0;
        last_seen_q <= 1'b0;
      end

      if (sv_cnt) begin
        vld_cnt_q <= vld_inc;
        if (last_sort_o) last_seen_q <= 1'b1;
      end

      if (sort_en) begin
        grp_cnt_q <= grp_cnt_q + GRP_W'(1);
        cnt_q     <= CNT_W'(SORT_GAP - 1);
      end else if ((state_q == GAP || state_q == DRAIN) && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
`ifdef SORT_TIMEOUT_EN
      if (state_d == DRAIN && state_q != DRAIN) cnt_q <= CNT_W'(TIMEOUT_CYC - 1);
`endif

      if ((fin && err_chk) || tmo) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_topk_sort_ctrl.sv
// Directed bench for topk_sort_ctrl: cycle tables for the main jobs plus hand sequences for corners.
module tb_topk_sort_ctrl;

  localparam int GW = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, src_valid = 1'b0;
  logic          sorter_valid = 1'b0, last_sort_o = 1'b0;
  logic [GW-1:0] num_groups = '0;
  logic          src_ready, sorter_clr, sort_en, last_sort, busy, done, err;
  logic [GW-1:0] grp_index;

  topk_sort_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort),
    .num_groups(num_groups), .src_valid(src_valid), .src_ready(src_ready),
    .sorter_clr(sorter_clr), .sort_en(sort_en), .last_sort(last_sort),
    .grp_index(grp_index), .sorter_valid(sorter_valid), .last_sort_o(last_sort_o),
    .busy(busy), .done(done), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          st;
    logic [GW-1:0] n;
    logic          svi, sval, lo, ab;
    logic          e_clr, e_en, e_last;
    logic [GW-1:0] e_idx;
    logic          e_done, e_busy, e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic st, logic [GW-1:0] n, logic svi, logic sval, logic lo,
                              logic ab, logic clr, logic en, logic lst, logic [GW-1:0] idx,
                              logic dn, logic bsy, logic er);
    vec_t v;
    v.st = st; v.n = n; v.svi = svi; v.sval = sval; v.lo = lo; v.ab = ab;
    v.e_clr = clr; v.e_en = en; v.e_last = lst; v.e_idx = idx;
    v.e_done = dn; v.e_busy = bsy; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then let combinational outputs settle.
  task automatic step(input logic st, input logic [GW-1:0] n, input logic svi,
                      input logic sval, input logic lo, input logic ab);
    @(negedge sys_clk);
    start = st; num_groups = n; src_valid = svi;
    sorter_valid = sval; last_sort_o = lo; abort = ab;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int en_cyc[$];
    int en_idx[$];
    int t3c[3];
    int done_c, clr_c, cnt_en;
    logic done_seen;

    // Job of 3 groups with src_valid held; E3 returns at 9/17/25.
    for (int i = 0; i < 28; i++)
      tv.push_back(mk(i == 0, 16'd3, 1'b1, (i == 9 || i == 17 || i == 25), i == 25, 1'b0,
                      i == 1, (i == 2 || i == 10 || i == 18), i == 18,
                      (i == 10) ? 16'd1 : (i == 18) ? 16'd2 : 16'd0,
                      i == 26, (i >= 1 && i <= 26), 1'b0));
    // Empty job: straight to done, no clear, no issue.
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(i == 0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b0, 16'd0, i == 1, i == 1, 1'b0));
    // Two groups, only one result back -> err, then cleared by the next (empty) start.
    for (int i = 0; i < 25; i++)
      tv.push_back(mk(i == 0 || i == 23, (i == 0) ? 16'd2 : 16'd0, 1'b1, i == 20, i == 20, 1'b0,
                      i == 1, (i == 2 || i == 10), i == 10, (i == 10) ? 16'd1 : 16'd0,
                      (i == 21 || i == 24), ((i >= 1 && i <= 21) || i == 24),
                      (i >= 21 && i <= 23)));

    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_clr",   0, sorter_clr, 0);
    chk("rst_en",    0, sort_en,    0);
    chk("rst_rdy",   0, src_ready,  0);
    chk("rst_last",  0, last_sort,  0);
    chk("rst_idx",   0, grp_index,  0);
    chk("rst_busy",  0, busy,       0);
    chk("rst_done",  0, done,       0);
    chk("rst_err",   0, err,        0);
    sys_rst_n = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].st, tv[i].n, tv[i].svi, tv[i].sval, tv[i].lo, tv[i].ab);
      chk("clr",  i, sorter_clr, tv[i].e_clr);
      chk("en",   i, sort_en,    tv[i].e_en);
      chk("rdy",  i, src_ready,  tv[i].e_en);
      chk("last", i, last_sort,  tv[i].e_last);
      chk("idx",  i, grp_index,  tv[i].e_idx);
      chk("done", i, done,       tv[i].e_done);
      chk("busy", i, busy,       tv[i].e_busy);
      chk("err",  i, err,        tv[i].e_err);
    end

    // Sparse src_valid: issue only when data present, in order, gap-respecting.
    t3c = '{5, 25, 45};
    done_c = -1;
    for (int c = 0; c < 60; c++) begin
      step(c == 0, 16'd3, (c == 5 || c == 25 || c == 45), (c == 12 || c == 32 || c == 52),
           c == 52, 1'b0);
      if (sort_en) begin
        en_cyc.push_back(c);
        en_idx.push_back(int'(grp_index));
        chk("t3_en_needs_valid", c, src_valid, 1);
      end
      if (done) done_c = c;
    end
    chk("t3_n_en", 0, en_cyc.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < en_cyc.size()) begin
        chk("t3_en_cyc", k, en_cyc[k], t3c[k]);
        chk("t3_en_idx", k, en_idx[k], k);
      end
    end
    chk("t3_done_cyc", 0, done_c, 53);
    chk("t3_err", 0, err, 0);

    // Abort during the gap after group 1; no done, clean return to idle.
    done_seen = 1'b0;
    cnt_en = 0;
    for (int c = 0; c < 16; c++) begin
      step(c == 0, 16'd3, 1'b1, 1'b0, 1'b0, c == 12);
      if (sort_en) cnt_en++;
      if (done) done_seen = 1'b1;
      if (c == 13) begin
        chk("t4_abort_clr",  c, sorter_clr, 1);
        chk("t4_abort_busy", c, busy, 1);
      end
      if (c == 14) begin
        chk("t4_idle_clr",  c, sorter_clr, 0);
        chk("t4_idle_busy", c, busy, 0);
      end
    end
    chk("t4_no_done", 0, done_seen, 0);
    chk("t4_n_en", 0, cnt_en, 2);
    // Abort in idle does nothing.
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4_idle_abort_clr",  c, sorter_clr, 0);
      chk("t4_idle_abort_busy", c, busy, 0);
    end
    // Fresh single-group job after the abort.
    for (int c = 0; c < 14; c++) begin
      step(c == 0, 16'd1, 1'b1, c == 11, c == 11, 1'b0);
      if (c == 1)  chk("t4b_clr", c, sorter_clr, 1);
      if (c == 2) begin
        chk("t4b_en",   c, sort_en, 1);
        chk("t4b_last", c, last_sort, 1);
      end
      if (c == 12) begin
        chk("t4b_done", c, done, 1);
        chk("t4b_err",  c, err, 0);
      end
      if (c == 13) chk("t4b_busy", c, busy, 0);
    end

    // Results never return: watchdog fires 64 cycles after drain entry (cycle 10), else hang busy.
    done_c = -1;
    clr_c  = -1;
    for (int c = 0; c < 120; c++) begin
      step(c == 0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (sorter_clr && c > 1 && clr_c < 0) begin
        clr_c = c;
        chk("t6_err_at_clr", c, err, 1);
      end
      if (done && done_c < 0) done_c = c;
    end
`ifdef SORT_TIMEOUT_EN
    chk("t6_clr_cyc",  0, clr_c, 74);
    chk("t6_done_cyc", 0, done_c, 75);
    chk("t6_err",      0, err, 1);
    chk("t6_busy",     0, busy, 0);
`else
    chk("t6_no_clr",  0, clr_c, -1);
    chk("t6_no_done", 0, done_c, -1);
    chk("t6_busy",    0, busy, 1);
`endif
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_final_idle", 0, busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
